// File: rtl/sparc_exu_sprsched_pkg.sv
// Shared EXU definitions for the sum-predict zero-detect scheduler.
package sparc_exu_sprsched_pkg;

   localparam int SPR_NREQ     = 4;
   localparam int SPR_DW       = 64;
   localparam int SPR_MAX_NREQ = 8;
   localparam int SPR_IDW_MAX  = 3;

   typedef struct packed {
      logic [SPR_IDW_MAX-1:0] id;
      logic                   z64;
      logic                   z32;
   } spr_resp_t;

   // Operand buses are zero-extended to the widest requester count before slicing.
   function automatic logic [SPR_DW-1:0] spr_slice(
      input logic [SPR_MAX_NREQ*SPR_DW-1:0] bus,
      input logic [SPR_IDW_MAX-1:0]         idx
   );
      spr_slice = bus[idx*SPR_DW +: SPR_DW];
   endfunction

endpackage

// File: rtl/sparc_exu_sprarb.sv
// Round-robin arbiter: one-hot grant searched upward from a wrapping pointer.
module sparc_exu_sprarb
   import sparc_exu_sprsched_pkg::*;
#(
   parameter int NREQ = SPR_NREQ,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic            rclk,
   input  logic            reset,
   input  logic [NREQ-1:0] req,
   input  logic            adv,
   output logic [NREQ-1:0] gnt,
   output logic            gnt_any,
   output logic [IDW-1:0]  gnt_idx,
   output logic [IDW-1:0]  id_p1
);

   logic [IDW-1:0] ptr;
   logic           en;

   assign en = adv & ~reset;

   always_comb begin
      logic [IDW-1:0] idx;
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      idx     = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = ptr + IDW'(k);
         if (en && !gnt_any && req[idx]) begin
            gnt[idx] = 1'b1;
            gnt_idx  = idx;
            gnt_any  = 1'b1;
         end
      end
   end

   always_ff @(posedge rclk) begin
      if (reset) begin
         ptr <= '0;
      end else if (gnt_any) begin
         ptr <= gnt_idx + IDW'(1);
      end
   end

   // S0 -> S1 boundary: winner id travels with the registered operands
   always_ff @(posedge rclk) begin
      if (reset) begin
         id_p1 <= '0;
      end else if (adv) begin
         id_p1 <= gnt_idx;
      end
   end

endmodule

// File: rtl/sparc_exu_sprsched.sv
// Shared zero-detect scheduler: round-robin grant, registered operands, registered sum-predict flags.
module sparc_exu_sprsched
   import sparc_exu_sprsched_pkg::*;
#(
   parameter int NREQ = SPR_NREQ,
   parameter int DW   = SPR_DW,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic               rclk,
   input  logic               reset,
   input  logic [NREQ-1:0]    req_vld,
   input  logic [NREQ*DW-1:0] req_rs1,
   input  logic [NREQ*DW-1:0] req_rs2,
   input  logic [NREQ-1:0]    req_cin,
   output logic [NREQ-1:0]    req_gnt,
   output logic               resp_vld,
   output logic [IDW-1:0]     resp_id,
   output logic               resp_z64,
   output logic               resp_z32,
   input  logic               resp_rdy
);

   logic                              stall;
   logic                              adv;
   logic                              gnt_any;
   logic [IDW-1:0]                    gnt_idx;
   logic [IDW-1:0]                    id_p1;
   logic [SPR_MAX_NREQ*SPR_DW-1:0]    rs1_ext;
   logic [SPR_MAX_NREQ*SPR_DW-1:0]    rs2_ext;
   logic [DW-1:0]                     rs1_p1;
   logic [DW-1:0]                     rs2_p1;
   logic                              cin_p1;
   logic                              vld_p1;
   logic [DW-1:0]                     or_p1;
   logic [DW-1:0]                     spr;
   spr_resp_t                         resp_d;
   spr_resp_t                         resp_p2;
   logic                              vld_p2;

   assign stall = vld_p2 & ~resp_rdy;
   assign adv   = ~stall;

   always_comb begin
      rs1_ext = '0;
      rs2_ext = '0;
      rs1_ext[NREQ*DW-1:0] = req_rs1;
      rs2_ext[NREQ*DW-1:0] = req_rs2;
   end

   sparc_exu_sprarb #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .rclk    (rclk),
      .reset   (reset),
      .req     (req_vld),
      .adv     (adv),
      .gnt     (req_gnt),
      .gnt_any (gnt_any),
      .gnt_idx (gnt_idx),
      .id_p1   (id_p1)
   );

   // S0 -> S1 boundary: capture the winner's operands
   always_ff @(posedge rclk) begin
      if (reset) begin
         vld_p1 <= 1'b0;
      end else if (adv) begin
         vld_p1 <= gnt_any;
      end
   end

   always_ff @(posedge rclk) begin
      if (adv && gnt_any) begin
         rs1_p1 <= spr_slice(rs1_ext, SPR_IDW_MAX'(gnt_idx));
         rs2_p1 <= spr_slice(rs2_ext, SPR_IDW_MAX'(gnt_idx));
         cin_p1 <= req_cin[gnt_idx];
      end
   end

   // Sum-predict: zero iff each propagate bit matches the carry implied by the bit below.
   assign or_p1 = rs1_p1 | rs2_p1;
   assign spr   = (rs1_p1 ^ rs2_p1) ^ {or_p1[DW-2:0], cin_p1};

   always_comb begin
      resp_d     = '0;
      resp_d.id  = SPR_IDW_MAX'(id_p1);
      resp_d.z64 = ~|spr;
      resp_d.z32 = ~|spr[31:0];
   end

   // S1 -> S2 boundary: result register drives the response port
   always_ff @(posedge rclk) begin
      if (reset) begin
         vld_p2  <= 1'b0;
         resp_p2 <= '0;
      end else if (adv) begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            resp_p2 <= resp_d;
         end
      end
   end

   assign resp_vld = vld_p2;
   assign resp_id  = IDW'(resp_p2.id);
   assign resp_z64 = resp_p2.z64;
   assign resp_z32 = resp_p2.z32;

endmodule

// File: tb/tb_sparc_exu_sprsched.sv
// Directed bench for the shared zero-detect scheduler.
module tb_sparc_exu_sprsched;

   localparam int NREQ = 4;
   localparam int DW   = 64;
   localparam int IDW  = 2;

   logic               rclk;
   logic               reset;
   logic [NREQ-1:0]    req_vld;
   logic [NREQ*DW-1:0] req_rs1;
   logic [NREQ*DW-1:0] req_rs2;
   logic [NREQ-1:0]    req_cin;
   logic [NREQ-1:0]    req_gnt;
   logic               resp_vld;
   logic [IDW-1:0]     resp_id;
   logic               resp_z64;
   logic               resp_z32;
   logic               resp_rdy;

   int n_assert;
   int n_fail;

   sparc_exu_sprsched #(
      .NREQ (NREQ),
      .DW   (DW),
      .IDW  (IDW)
   ) dut (
      .rclk     (rclk),
      .reset    (reset),
      .req_vld  (req_vld),
      .req_rs1  (req_rs1),
      .req_rs2  (req_rs2),
      .req_cin  (req_cin),
      .req_gnt  (req_gnt),
      .resp_vld (resp_vld),
      .resp_id  (resp_id),
      .resp_z64 (resp_z64),
      .resp_z32 (resp_z32),
      .resp_rdy (resp_rdy)
   );

   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   task automatic cyc();
      @(posedge rclk);
      #1;
   endtask

   task automatic smp();
      @(negedge rclk);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_resp(input string tag, input logic vld, input logic [1:0] id,
                           input logic z64, input logic z32);
      chk({tag, "_vld"}, 64'(resp_vld), 64'(vld));
      chk({tag, "_id"},  64'(resp_id),  64'(id));
      chk({tag, "_z64"}, 64'(resp_z64), 64'(z64));
      chk({tag, "_z32"}, 64'(resp_z32), 64'(z32));
   endtask

   task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b, input logic c);
      req_vld[i]         = 1'b1;
      req_rs1[i*DW +: DW] = a;
      req_rs2[i*DW +: DW] = b;
      req_cin[i]         = c;
   endtask

   // One isolated transaction: grant now, nothing next cycle, response two cycles after grant.
   task automatic single(input string tag, input int i, input logic [63:0] a, input logic [63:0] b,
                         input logic c, input logic z64, input logic z32);
      set_req(i, a, b, c);
      smp();
      chk({tag, "_gnt"}, 64'(req_gnt), 64'(4'b0001 << i));
      cyc();
      req_vld[i] = 1'b0;
      smp();
      chk({tag, "_lat1"}, 64'(resp_vld), 64'(0));
      cyc();
      smp();
      chk_resp(tag, 1'b1, 2'(i), z64, z32);
      cyc();
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      reset    = 1'b1;
      resp_rdy = 1'b1;
      req_vld  = '0;
      req_rs1  = '0;
      req_rs2  = '0;
      req_cin  = '0;

      // reset state, with a pending request that must not be granted
      set_req(0, 64'd0, 64'd0, 1'b0);
      cyc();
      cyc();
      smp();
      chk("rst_gnt", 64'(req_gnt), 64'(0));
      chk_resp("rst", 1'b0, 2'd0, 1'b0, 1'b0);
      cyc();
      reset   = 1'b0;
      req_vld = '0;

      single("t1_r0", 0, 64'd5, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0, 1'b1, 1'b1);
      single("t2_cin1", 2, 64'h1234, ~64'h1234, 1'b1, 1'b1, 1'b1);
      single("t2_cin0", 2, 64'h1234, ~64'h1234, 1'b0, 1'b0, 1'b0);
      single("t3_hi", 1, 64'h1_0000_0000, 64'd0, 1'b0, 1'b0, 1'b1);
      single("t4_r3", 3, 64'd1, 64'd0, 1'b0, 1'b0, 1'b0);

      // fairness: all requesters held valid, pointer starts at 0
      for (int i = 0; i < NREQ; i++) set_req(i, 64'(i) << 32, 64'd0, 1'b0);
      for (int c = 0; c < 10; c++) begin
         if (c == 8) req_vld = '0;
         smp();
         chk("fair_gnt", 64'(req_gnt), (c < 8) ? 64'(4'b0001 << (c % 4)) : 64'd0);
         if (c >= 2) chk_resp("fair", 1'b1, 2'((c - 2) % 4), ((c - 2) % 4) == 0, 1'b1);
         else        chk("fair_pre", 64'(resp_vld), 64'(0));
         cyc();
      end
      smp();
      chk("fair_end", 64'(resp_vld), 64'(0));
      cyc();

      // stall: response held while req3 waits
      set_req(0, 64'h1_0000_0000, 64'd0, 1'b0);
      smp();
      chk("st_gnt0", 64'(req_gnt), 64'(4'b0001));
      cyc();
      req_vld[0] = 1'b0;
      smp();
      chk("st_lat1", 64'(resp_vld), 64'(0));
      cyc();
      resp_rdy = 1'b0;
      set_req(3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0);
      for (int s = 0; s < 3; s++) begin
         smp();
         chk("st_hold_gnt", 64'(req_gnt), 64'(0));
         chk_resp("st_hold", 1'b1, 2'd0, 1'b0, 1'b1);
         cyc();
      end
      resp_rdy = 1'b1;
      smp();
      chk("st_rel_gnt", 64'(req_gnt), 64'(4'b1000));
      chk_resp("st_rel", 1'b1, 2'd0, 1'b0, 1'b1);
      cyc();
      req_vld[3] = 1'b0;
      smp();
      chk("st_bubble", 64'(resp_vld), 64'(0));
      cyc();
      smp();
      chk_resp("st_r3", 1'b1, 2'd3, 1'b1, 1'b1);
      cyc();

      // reset with S1 and S2 both occupied
      set_req(1, 64'd0, 64'd0, 1'b0);
      smp();
      chk("mr_gnt1", 64'(req_gnt), 64'(4'b0010));
      cyc();
      req_vld[1] = 1'b0;
      set_req(2, 64'd0, 64'd0, 1'b0);
      smp();
      chk("mr_gnt2", 64'(req_gnt), 64'(4'b0100));
      cyc();
      req_vld  = '0;
      resp_rdy = 1'b0;
      reset    = 1'b1;
      smp();
      chk("mr_inflight", 64'(resp_vld), 64'(1));
      cyc();
      reset    = 1'b0;
      resp_rdy = 1'b1;
      smp();
      chk_resp("mr_flush", 1'b0, 2'd0, 1'b0, 1'b0);
      cyc();
      smp();
      chk("mr_flush2", 64'(resp_vld), 64'(0));
      cyc();
      for (int i = 1; i < NREQ; i++) set_req(i, 64'd0, 64'd0, 1'b0);
      smp();
      chk("mr_ptr_a", 64'(req_gnt), 64'(4'b0010));
      cyc();
      smp();
      chk("mr_ptr_b", 64'(req_gnt), 64'(4'b0100));
      cyc();
      smp();
      chk("mr_ptr_c", 64'(req_gnt), 64'(4'b1000));
      chk_resp("mr_resp", 1'b1, 2'd1, 1'b1, 1'b1);
      cyc();
      req_vld = '0;
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
